// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared DDR5 timing defaults, command encoding and request layout for the DRAM command sequencer.
// Timing values are in DIMM command-clock cycles.
package dram_cmd_sequencer_pkg;

    localparam int tRCD   = 39;
    localparam int tCAS   = 40;
    localparam int tCWL   = 38;
    localparam int tBURST = 8;
    localparam int tWR    = 72;
    localparam int tRP    = 39;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD0  = 3'd3,
        CMD_RD1  = 3'd4,
        CMD_WR0  = 3'd5,
        CMD_WR1  = 3'd6,
        CMD_PRE  = 3'd7
    } dram_cmd_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [35:0] addr;
    } req_t;

    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_ERR = 2'd3;

    // Address slices feeding the command bus fields.
    localparam int CH_BIT   = 6;
    localparam int BG_MSB   = 9;
    localparam int BG_LSB   = 7;
    localparam int BA_MSB   = 11;
    localparam int BA_LSB   = 10;
    localparam int ROW_MSB  = 33;
    localparam int ROW_LSB  = 18;
    localparam int COLH_MSB = 17;
    localparam int COLH_LSB = 12;
    localparam int COLL_MSB = 5;
    localparam int COLL_LSB = 2;

endpackage

// File: rtl/dram_cmd_sequencer_timer.sv
// Reusable wait counter: loads a cycle count and decrements to a saturating zero.
// expired marks the final cycle of a loaded wait (count at 1) or an idle counter (count at 0).
module dram_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: one request in flight, ACT/CAS/PRE with tRCD/tCAS/tCWL/tWR/tRP enforced.
// Commands are decoded combinationally from the state register; req_ready is high only in IDLE.
module dram_cmd_sequencer
    import dram_cmd_sequencer_pkg::*;
#(
    parameter int T_RCD   = tRCD,
    parameter int T_CAS   = tCAS,
    parameter int T_CWL   = tCWL,
    parameter int T_BURST = tBURST,
    parameter int T_WR    = tWR,
    parameter int T_RP    = tRP,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [37:0] req_data,
    output logic        req_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        cmd_ch,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done,
    output logic        err_op,
    output logic [63:0] cycle_cnt
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ACT0     = 4'd1;
    localparam logic [3:0] S_ACT1     = 4'd2;
    localparam logic [3:0] S_WAIT_RCD = 4'd3;
    localparam logic [3:0] S_CAS0     = 4'd4;
    localparam logic [3:0] S_CAS1     = 4'd5;
    localparam logic [3:0] S_WAIT_PRE = 4'd6;
    localparam logic [3:0] S_PRE      = 4'd7;
    localparam logic [3:0] S_WAIT_RP  = 4'd8;

    if (T_RCD >= 2**CNT_W || T_CAS + T_BURST >= 2**CNT_W ||
        T_CWL + T_BURST + T_WR >= 2**CNT_W || T_RP >= 2**CNT_W) begin : g_bad_timing
        $error("dram_cmd_sequencer: timing interval does not fit CNT_W");
    end

    // Wait length = interval minus the command phases already spent, floored at zero.
    function automatic logic [CNT_W-1:0] wait_of(input int ival, input int elapsed);
        logic [CNT_W:0] iv, el;
        iv = (CNT_W+1)'(ival);
        el = (CNT_W+1)'(elapsed);
        return (iv > el) ? CNT_W'(iv - el) : '0;
    endfunction

    localparam int RCD_EFF = (T_RCD < 2) ? 2 : T_RCD;
    localparam logic [CNT_W-1:0] W_RCD    = wait_of(RCD_EFF, 2);
    localparam logic [CNT_W-1:0] W_PRE_RD = wait_of(T_CAS + T_BURST, 2);
    localparam logic [CNT_W-1:0] W_PRE_WR = wait_of(T_CWL + T_BURST + T_WR, 2);
    localparam logic [CNT_W-1:0] W_RP     = wait_of(T_RP, 1);

    logic [3:0]       state_q, state_d;
    req_t             req_q, req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [63:0]      cyc_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;
    logic             is_wr;
    dram_cmd_e        code;

    assign is_wr = (req_q.op == OP_WR);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d = req_t'(req_data);
                    if (req_data[37:36] == OP_ERR) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_ACT0;
                    end
                end
            end
            S_ACT0: state_d = S_ACT1;
            S_ACT1: begin
                tmr_val = W_RCD;
                if (W_RCD == '0) begin
                    state_d = S_CAS0;
                end else begin
                    state_d  = S_WAIT_RCD;
                    tmr_load = 1'b1;
                end
            end
            S_WAIT_RCD: if (tmr_exp) state_d = S_CAS0;
            S_CAS0: state_d = S_CAS1;
            S_CAS1: begin
                tmr_val = is_wr ? W_PRE_WR : W_PRE_RD;
                if (tmr_val == '0) begin
                    state_d = S_PRE;
                end else begin
                    state_d  = S_WAIT_PRE;
                    tmr_load = 1'b1;
                end
            end
            S_WAIT_PRE: if (tmr_exp) state_d = S_PRE;
            S_PRE: begin
                tmr_val = W_RP;
                if (W_RP == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_WAIT_RP;
                    tmr_load = 1'b1;
                end
            end
            S_WAIT_RP: begin
                if (tmr_exp) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_q + 64'd1;
        end
    end

    dram_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        code = CMD_NOP;
        case (state_q)
            S_ACT0:  code = CMD_ACT0;
            S_ACT1:  code = CMD_ACT1;
            S_CAS0:  code = is_wr ? CMD_WR0 : CMD_RD0;
            S_CAS1:  code = is_wr ? CMD_WR1 : CMD_RD1;
            S_PRE:   code = CMD_PRE;
            default: code = CMD_NOP;
        endcase
    end

    logic unused_addr;
    assign unused_addr = ^{req_q.addr[35:34], req_q.addr[1:0]};

    assign req_ready = (state_q == S_IDLE);
    assign cmd_code  = code;
    assign cmd_valid = (code != CMD_NOP);
    assign cmd_ch    = req_q.addr[CH_BIT];
    assign cmd_bg    = req_q.addr[BG_MSB:BG_LSB];
    assign cmd_ba    = req_q.addr[BA_MSB:BA_LSB];
    assign cmd_row   = req_q.addr[ROW_MSB:ROW_LSB];
    assign cmd_col   = {req_q.addr[COLH_MSB:COLH_LSB], req_q.addr[COLL_MSB:COLL_LSB]};
    assign done      = done_q;
    assign err_op    = err_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: expected command/done/err events are queued at stimulus time
// and matched by a negedge monitor; a second instance exercises the T_RCD clamp.
module tb_dram_cmd_sequencer;

    localparam int RCD = 39, CAS = 40, CWL = 38, BURST = 8, WR = 72, RP = 39;
    localparam logic [2:0] NOP = 3'd0, ACT0 = 3'd1, ACT1 = 3'd2, RD0 = 3'd3, RD1 = 3'd4,
                           WR0 = 3'd5, WR1 = 3'd6, PRE = 3'd7;

    typedef struct packed {
        logic [63:0] cyc;
        logic [2:0]  code;
        logic        ch;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, cmd_valid, cmd_ch, done, err_op;
    logic [37:0] req_data;
    logic [2:0]  cmd_code, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [63:0] cycle_cnt;

    logic        c_req_valid, c_req_ready, c_cmd_valid, c_cmd_ch, c_done, c_err_op;
    logic [37:0] c_req_data;
    logic [2:0]  c_cmd_code, c_cmd_bg;
    logic [1:0]  c_cmd_ba;
    logic [15:0] c_cmd_row;
    logic [9:0]  c_cmd_col;
    logic [63:0] c_cycle_cnt;

    logic [63:0] tb_cyc;
    ev_t         evq[$];
    logic [63:0] doneq[$];
    logic [63:0] errq[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    dram_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ch(cmd_ch), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .err_op(err_op), .cycle_cnt(cycle_cnt)
    );

    dram_cmd_sequencer #(.T_RCD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_data(c_req_data), .req_ready(c_req_ready),
        .cmd_valid(c_cmd_valid), .cmd_code(c_cmd_code), .cmd_ch(c_cmd_ch), .cmd_bg(c_cmd_bg),
        .cmd_ba(c_cmd_ba), .cmd_row(c_cmd_row), .cmd_col(c_cmd_col), .done(c_done), .err_op(c_err_op),
        .cycle_cnt(c_cycle_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input logic [63:0] c, input logic [2:0] code, input logic [35:0] a);
        ev_t e;
        e.cyc  = c;
        e.code = code;
        e.ch   = a[6];
        e.bg   = a[9:7];
        e.ba   = a[11:10];
        e.row  = a[33:18];
        e.col  = {a[17:12], a[5:2]};
        return e;
    endfunction

    // Queue the full command timeline of a request accepted on the edge ending cycle k.
    task automatic push_req(input logic [63:0] k, input logic [1:0] op, input logic [35:0] a);
        logic [63:0] c, p;
        bit rd;
        if (op == 2'd3) begin
            errq.push_back(k + 1);
            return;
        end
        rd = (op != 2'd1);
        c  = k + 1 + RCD;
        p  = rd ? c + CAS + BURST : c + CWL + BURST + WR;
        evq.push_back(mk(k + 1, ACT0, a));
        evq.push_back(mk(k + 2, ACT1, a));
        evq.push_back(mk(c, rd ? RD0 : WR0, a));
        evq.push_back(mk(c + 1, rd ? RD1 : WR1, a));
        evq.push_back(mk(p, PRE, a));
        doneq.push_back(p + RP);
    endtask

    task automatic at_cyc(input logic [63:0] c);
        int n = 0;
        @(negedge clk);
        while (tb_cyc != c && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("wait_timeout", tb_cyc, c);
    endtask

    task automatic send(input logic [63:0] k, input logic [1:0] op, input logic [35:0] a);
        at_cyc(k);
        check("ready_at_accept", req_ready, 1'b1);
        req_valid = 1'b1;
        req_data  = {op, a};
        push_req(k, op, a);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = {6'($urandom), 32'($urandom)};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_cmd"}, {cmd_valid, cmd_code}, 4'd0);
        check({tag, "_fields"}, {cmd_ch, cmd_bg, cmd_ba, cmd_row, cmd_col}, 32'd0);
        check({tag, "_pulses"}, {done, err_op}, 2'b00);
        check({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle_cnt", cycle_cnt, tb_cyc);
            if (cmd_valid) begin
                if (evq.size() == 0) check("cmd_valid_unexpected", cmd_valid, 1'b0);
                else check("cmd_event", {tb_cyc, cmd_code, cmd_ch, cmd_bg, cmd_ba, cmd_row, cmd_col},
                           evq.pop_front());
            end else begin
                check("nop_when_idle", cmd_code, NOP);
            end
            if (done) begin
                if (doneq.size() == 0) check("done_unexpected", done, 1'b0);
                else check("done_cycle", tb_cyc, doneq.pop_front());
            end
            if (err_op) begin
                if (errq.size() == 0) check("err_unexpected", err_op, 1'b0);
                else check("err_cycle", tb_cyc, errq.pop_front());
            end
        end
    end

    initial begin
        logic [2:0] exp_c [4];
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_data    = '0;
        c_req_valid = 1'b0;
        c_req_data  = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Read at cycle 10: ACT0@11 ... PRE@98, done@137.
        send(10, 2'd0, 36'h0_1234_5AC0);
        check("fields_abs", {cmd_row, cmd_col, cmd_bg, cmd_ba, cmd_ch},
              {16'h048D, 10'h050, 3'd5, 2'd2, 1'b1});
        check("busy_not_ready", req_ready, 1'b0);
        at_cyc(136);
        check("ready_before_done", req_ready, 1'b0);
        at_cyc(137);
        check("ready_at_done", {req_ready, done}, 2'b11);

        // Write at cycle 150: WR0@190, PRE@308, done@347.
        send(150, 2'd1, 36'h9_8765_4321);

        // op==3: error pulse only.
        send(360, 2'd3, 36'h0_0000_0FFF);
        check("err_ready_k1", {req_ready, cmd_valid}, 2'b10);
        at_cyc(362);
        check("err_ready_k2", {req_ready, err_op}, 2'b10);

        // ifetch then read held valid: second accept on the edge ending the done cycle (497).
        at_cyc(370);
        req_valid = 1'b1;
        req_data  = {2'd2, 36'h5_5AA5_3C3C};
        push_req(370, 2'd2, 36'h5_5AA5_3C3C);
        @(negedge clk);
        req_data = {2'd0, 36'hA_0F0F_1E1E};
        push_req(497, 2'd0, 36'hA_0F0F_1E1E);
        at_cyc(496);
        check("b2b_busy", req_ready, 1'b0);
        at_cyc(497);
        check("b2b_ready_at_done", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_act0_busy", {req_ready, cmd_code}, {1'b0, ACT0});

        // Reset while waiting for precharge: pending PRE/done are abandoned.
        send(640, 2'd0, 36'h3_1111_2222);
        at_cyc(700);
        void'(evq.pop_back());
        void'(doneq.pop_back());
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(5, 2'd0, 36'h7_7777_8888);

        // T_RCD=1 instance: clamped to 2, so RD0 lands two cycles after ACT0.
        exp_c = '{ACT0, ACT1, RD0, RD1};
        at_cyc(140);
        c_req_valid = 1'b1;
        c_req_data  = {2'd0, 36'h0_1234_5AC0};
        @(negedge clk);
        c_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clamp_code_%0d", i), {c_cmd_valid, c_cmd_code}, {1'b1, exp_c[i]});
            @(negedge clk);
        end
        at_cyc(230);
        check("clamp_done", {c_done, c_req_ready}, 2'b11);

        at_cyc(240);
        check("evq_drained", evq.size(), 0);
        check("doneq_drained", doneq.size(), 0);
        check("errq_drained", errq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
